// File: rtl/pipeline_hazard_ctrl_pkg.sv
// rtl/pipeline_hazard_ctrl_pkg.sv - shared processor package for the hazard controller
// Purpose: FSM state encodings and ALU operand forwarding select codes.
// Contents: hz_state_e (RUN, LU_STALL, FREEZE, REDIRECT), FWD_RF, FWD_MEM, FWD_WB,
//           DRAIN_CYCLES (length of the post-redirect drain window).
package pipeline_hazard_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    LU_STALL = 2'd1,
    FREEZE   = 2'd2,
    REDIRECT = 2'd3
  } hz_state_e;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_MEM = 2'b01;
  localparam logic [1:0] FWD_WB  = 2'b10;

  localparam logic [1:0] DRAIN_CYCLES = 2'd3;

endpackage

// File: rtl/pipeline_hazard_ctrl_fwd_select.sv
// rtl/pipeline_hazard_ctrl_fwd_select.sv - operand forwarding select for one ALU source
// Purpose: pick the ALU operand source for one EX register field; MEM beats WB,
//          register $0 is never forwarded, purely combinational.
// Ports:
//   src          in  5  EX-stage source register field
//   mem_rd       in  5  MEM-stage destination register
//   mem_regwrite in  1  MEM-stage instruction writes a register
//   mem_valid    in  1  MEM stage holds a valid instruction
//   wb_rd        in  5  WB-stage destination register
//   wb_regwrite  in  1  WB-stage instruction writes a register
//   wb_valid     in  1  WB stage holds a valid instruction
//   sel          out 2  FWD_RF / FWD_MEM / FWD_WB
module fwd_select
  import pipeline_hazard_ctrl_pkg::*;
(
  input  logic [4:0] src,
  input  logic [4:0] mem_rd,
  input  logic       mem_regwrite,
  input  logic       mem_valid,
  input  logic [4:0] wb_rd,
  input  logic       wb_regwrite,
  input  logic       wb_valid,
  output logic [1:0] sel
);

  logic mem_hit;
  logic wb_hit;

  assign mem_hit = mem_regwrite && mem_valid && (mem_rd != 5'd0) && (mem_rd == src);
  assign wb_hit  = wb_regwrite  && wb_valid  && (wb_rd  != 5'd0) && (wb_rd  == src);

  always_comb begin
    sel = FWD_RF;
    if (mem_hit) begin
      sel = FWD_MEM;
    end else if (wb_hit) begin
      sel = FWD_WB;
    end
  end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// rtl/pipeline_hazard_ctrl.sv - 5-stage pipeline hazard controller (stall, freeze, redirect, forwarding)
// Purpose: resolves load-use stalls, data-memory freezes and MEM-stage redirects,
//          tracks per-stage valid bits and drives operand forwarding selects.
// Optional feature: define HAZARD_PERF_CNT_EN to add saturating performance counters.
// Ports:
//   clk, reset                       in   clock, synchronous active-high reset
//   id_rs, id_rt, id_uses_rt         in   ID-stage source fields and rt-use flag
//   ex_rs, ex_rt, ex_rd              in   EX-stage register fields
//   ex_regwrite, ex_memread          in   EX-stage controls
//   mem_rd, mem_regwrite             in   MEM-stage destination and write flag
//   wb_rd, wb_regwrite               in   WB-stage destination and write flag
//   mem_redirect                     in   control transfer resolved in MEM
//   dmem_wait                        in   data memory not ready
//   pc_en .. mem_wb_en               out  pipe-register enables
//   if_id_flush .. ex_mem_flush      out  load a bubble into that pipe register
//   fwd_a, fwd_b                     out  ALU operand sources
//   stage_valid                      out  {WB,MEM,EX,ID} valid bits
//   state                            out  current FSM state
//   stall_cnt, flush_cnt, freeze_cnt out  (HAZARD_PERF_CNT_EN only) event counters
module pipeline_hazard_ctrl
  import pipeline_hazard_ctrl_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic             id_uses_rt,
  input  logic [4:0]       ex_rs,
  input  logic [4:0]       ex_rt,
  input  logic [4:0]       ex_rd,
  input  logic             ex_regwrite,
  input  logic             ex_memread,
  input  logic [4:0]       mem_rd,
  input  logic             mem_regwrite,
  input  logic [4:0]       wb_rd,
  input  logic             wb_regwrite,
  input  logic             mem_redirect,
  input  logic             dmem_wait,
  output logic             pc_en,
  output logic             if_id_en,
  output logic             id_ex_en,
  output logic             ex_mem_en,
  output logic             mem_wb_en,
  output logic             if_id_flush,
  output logic             id_ex_flush,
  output logic             ex_mem_flush,
  output logic [1:0]       fwd_a,
  output logic [1:0]       fwd_b,
  output logic [3:0]       stage_valid,
  output logic [1:0]       state
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt,
  output logic [CNT_W-1:0] freeze_cnt
`endif
);

  // valid bit positions: [3]=WB, [2]=MEM, [1]=EX, [0]=ID
  hz_state_e  state_q, state_d;
  logic [3:0] valid_q, valid_d;
  logic [1:0] drain_q, drain_d;

  logic       load_use;
  logic       ev_freeze;
  logic       ev_redirect;
  logic       ev_load_use;
  logic [1:0] fwd_a_raw;
  logic [1:0] fwd_b_raw;

  // Any load writes its destination, so ex_regwrite adds nothing to detection.
  logic       unused_ex_regwrite;
  assign unused_ex_regwrite = ex_regwrite;

  // The bubble behind a stalled load must not re-trigger, hence the LU_STALL mask.
  assign load_use = ex_memread && valid_q[1] && valid_q[0] && (ex_rd != 5'd0) &&
                    ((ex_rd == id_rs) || (id_uses_rt && (ex_rd == id_rt))) &&
                    (state_q != LU_STALL);

  assign ev_freeze   = dmem_wait;
  assign ev_redirect = !dmem_wait && mem_redirect && valid_q[2];
  assign ev_load_use = !dmem_wait && !ev_redirect && load_use;

  always_comb begin
    pc_en        = 1'b1;
    if_id_en     = 1'b1;
    id_ex_en     = 1'b1;
    ex_mem_en    = 1'b1;
    mem_wb_en    = 1'b1;
    if_id_flush  = 1'b0;
    id_ex_flush  = 1'b0;
    ex_mem_flush = 1'b0;
    state_d      = state_q;
    drain_d      = drain_q;
    valid_d      = {valid_q[2:0], 1'b1};

    if (ev_freeze) begin
      // Whole pipe holds; drain count and valid bits wait for release.
      pc_en     = 1'b0;
      if_id_en  = 1'b0;
      id_ex_en  = 1'b0;
      ex_mem_en = 1'b0;
      mem_wb_en = 1'b0;
      valid_d   = valid_q;
      state_d   = FREEZE;
    end else if (ev_redirect) begin
      // Redirecting instruction retires into WB; everything younger is squashed.
      if_id_flush  = 1'b1;
      id_ex_flush  = 1'b1;
      ex_mem_flush = 1'b1;
      valid_d      = {valid_q[2], 3'b000};
      state_d      = REDIRECT;
      drain_d      = DRAIN_CYCLES;
    end else if (ev_load_use) begin
      // Hold PC and IF/ID, inject one bubble into EX, let older stages move.
      pc_en       = 1'b0;
      if_id_en    = 1'b0;
      id_ex_flush = 1'b1;
      valid_d     = {valid_q[2], valid_q[1], 1'b0, valid_q[0]};
      state_d     = LU_STALL;
      drain_d     = 2'd0;
    end else if (drain_q != 2'd0) begin
      // Resume or continue a drain window, including after a freeze.
      drain_d = drain_q - 2'd1;
      state_d = (drain_q == 2'd1) ? RUN : REDIRECT;
    end else begin
      state_d = RUN;
    end

    if (reset) begin
      pc_en        = 1'b1;
      if_id_en     = 1'b1;
      id_ex_en     = 1'b1;
      ex_mem_en    = 1'b1;
      mem_wb_en    = 1'b1;
      if_id_flush  = 1'b1;
      id_ex_flush  = 1'b1;
      ex_mem_flush = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= RUN;
      valid_q <= 4'b0000;
      drain_q <= 2'd0;
    end else begin
      state_q <= state_d;
      valid_q <= valid_d;
      drain_q <= drain_d;
    end
  end

  fwd_select u_fwd_a (
    .src          (ex_rs),
    .mem_rd       (mem_rd),
    .mem_regwrite (mem_regwrite),
    .mem_valid    (valid_q[2]),
    .wb_rd        (wb_rd),
    .wb_regwrite  (wb_regwrite),
    .wb_valid     (valid_q[3]),
    .sel          (fwd_a_raw)
  );

  fwd_select u_fwd_b (
    .src          (ex_rt),
    .mem_rd       (mem_rd),
    .mem_regwrite (mem_regwrite),
    .mem_valid    (valid_q[2]),
    .wb_rd        (wb_rd),
    .wb_regwrite  (wb_regwrite),
    .wb_valid     (valid_q[3]),
    .sel          (fwd_b_raw)
  );

  assign fwd_a       = reset ? FWD_RF : fwd_a_raw;
  assign fwd_b       = reset ? FWD_RF : fwd_b_raw;
  assign stage_valid = reset ? 4'b0000 : valid_q;
  assign state       = reset ? RUN : state_q;

`ifdef HAZARD_PERF_CNT_EN
  logic [CNT_W-1:0] stall_q, flush_q, freeze_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      stall_q  <= '0;
      flush_q  <= '0;
      freeze_q <= '0;
    end else begin
      if (ev_load_use && (stall_q != '1)) begin
        stall_q <= stall_q + 1'b1;
      end
      if (ev_redirect && (flush_q != '1)) begin
        flush_q <= flush_q + 1'b1;
      end
      if (ev_freeze && (freeze_q != '1)) begin
        freeze_q <= freeze_q + 1'b1;
      end
    end
  end

  assign stall_cnt  = reset ? '0 : stall_q;
  assign flush_cnt  = reset ? '0 : flush_q;
  assign freeze_cnt = reset ? '0 : freeze_q;
`endif

endmodule

// File: doc/pipeline_hazard_ctrl.md
PIPELINE_HAZARD_CTRL -- requirements
Module: pipeline_hazard_ctrl

Interface
REQ-001 SHALL have parameter CNT_W, default 32, width of the performance counters.
REQ-002 SHALL have port clk, input, 1, single clock; all state updates on rising edge.
REQ-003 SHALL have port reset, input, 1, synchronous, active-high.
REQ-004 SHALL have ports id_rs, id_rt, input, 5 each, source register fields of the instruction in ID.
REQ-005 SHALL have port id_uses_rt, input, 1, ID instruction reads rt (R-type, beq/bne, sw).
REQ-006 SHALL have ports ex_rs, ex_rt, ex_rd, input, 5 each; ex_regwrite, ex_memread, input, 1 each; EX-stage register fields and controls.
REQ-007 SHALL have ports mem_rd, wb_rd, input, 5 each; mem_regwrite, wb_regwrite, input, 1 each.
REQ-008 SHALL have port mem_redirect, input, 1, taken branch, j, jal or jr resolved in MEM.
REQ-009 SHALL have port dmem_wait, input, 1, data memory not ready.
REQ-010 SHALL have outputs pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en, 1 each, pipe-register enables.
REQ-011 SHALL have outputs if_id_flush, id_ex_flush, ex_mem_flush, 1 each, load a bubble (all zero) into that pipe register.
REQ-012 SHALL have outputs fwd_a, fwd_b, 2 each, ALU operand source: 00 register file, 01 MEM result, 10 WB result.
REQ-013 SHALL have output stage_valid, 4, valid bits {WB,MEM,EX,ID}.
REQ-014 SHALL have output state, 2, current FSM state.

Function
REQ-015 SHALL implement FSM states RUN=0, LU_STALL=1, FREEZE=2, REDIRECT=3.
REQ-016 SHALL evaluate events per cycle in priority: dmem_wait > mem_redirect (MEM valid) > load-use > none.
REQ-017 Load-use SHALL be detected when ex_memread, EX valid, ID valid, ex_rd!=0 and (ex_rd==id_rs or (id_uses_rt and ex_rd==id_rt)).
REQ-018 On load-use: pc_en=0, if_id_en=0, id_ex_flush=1 in the same cycle; next state LU_STALL; exactly one bubble per load.
REQ-019 LU_STALL SHALL last one cycle, not re-detect against the bubble, then return to RUN.
REQ-020 On dmem_wait: all five enables 0, no flush asserted, stage_valid held; state FREEZE while asserted; previous event re-evaluated on release.
REQ-021 On mem_redirect with MEM valid and no dmem_wait: pc_en=1, if_id_flush, id_ex_flush, ex_mem_flush all 1; next state REDIRECT.
REQ-022 REDIRECT SHALL drain for 3 cycles (2-bit down-counter) while younger stages refill; load-use detection applies only to valid stages; a new redirect during drain restarts the counter.
REQ-023 stage_valid SHALL shift ID->EX->MEM->WB each enabled cycle; ID valid set on fetch; flushed stages cleared.
REQ-024 fwd_a SHALL be 01 if mem_regwrite, MEM valid, mem_rd!=0, mem_rd==ex_rs; else 10 if same for WB; else 00; fwd_b identical with ex_rt; MEM beats WB.
REQ-025 Forwarding SHALL be combinational, zero latency; register $0 is never forwarded.
REQ-026 With no hazard all enables SHALL be 1 and all flushes 0.

Reset
REQ-027 During reset: state=RUN, stage_valid=0000, drain counter=0, counters=0, fwd_a=fwd_b=00, all flushes 1, all enables 1.
REQ-028 Reset mid-stall, mid-freeze or mid-redirect SHALL abort it; first cycle after reset behaves as RUN with empty pipe.

Configuration
REQ-029 Macro HAZARD_PERF_CNT_EN SHALL, when defined, add outputs stall_cnt, flush_cnt, freeze_cnt (CNT_W each) counting load-use stalls, redirects and FREEZE cycles, saturating at all-ones.
REQ-030 Without HAZARD_PERF_CNT_EN the ports and counter logic SHALL be absent; all other behaviour identical.

Structure
REQ-031 State encodings and fwd select codes (FWD_RF, FWD_MEM, FWD_WB) SHALL live in the shared processor package.
REQ-032 Forwarding compare SHALL be one sub-module, fwd_select, instantiated twice (operands A and B).

Verification
REQ-033 lw $t0 then add $t1,$t0,$t2 -> one cycle pc_en=0, id_ex_flush=1, state LU_STALL, then fwd_a=10.
REQ-034 add $t0 then sub using $t0 next -> fwd_a=01, no stall; repeat with one-instruction gap -> fwd_a=10.
REQ-035 beq taken (mem_redirect=1) while load-use also detected -> three flushes asserted, no stall, stage_valid=1000 next cycle.
REQ-036 dmem_wait held 4 cycles during redirect -> all enables 0 for 4 cycles, then redirect flush on release.
REQ-037 Write to $0 from MEM with ex_rs=0 -> fwd_a=00.
REQ-038 reset asserted in LU_STALL -> state RUN, stage_valid=0000, counters 0 next cycle.
